cacheline_adaptor: RTL and testbench

- Sits directly downstream of the cache datapath/controller. Converts one full-line transaction on the cache side into a sequence of bursts on the physical-memory side.
- A line fill gathers n_bursts incoming bursts into one line. A writeback splits the evicted line into n_bursts outgoing bursts.
- Handles one transaction at a time, with a request/response handshake on both sides.

---
 rtl/cacheline_adaptor_if.sv | 30 +++
 rtl/cacheline_adaptor.sv | 149 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and pmem-side signal bundle for the cache-line adaptor.
// slave = adaptor view, master = view of the environment driving both sides.
interface cacheline_adaptor_if #(
  parameter int S_LINE  = 256,
  parameter int S_BURST = 64
);
  logic [S_LINE-1:0]  line_i;
  logic [S_LINE-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [S_BURST-1:0] burst_i;
  logic [S_BURST-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;
  logic               error_o;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o, error_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o, error_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one cache-line fill/writeback into N_BURSTS pmem beats; resp_o one cycle after the last beat.
// Optional CACHELINE_ADAPTOR_TIMEOUT_EN: abort a burst after 255 stalled cycles and pulse error_o.
module cacheline_adaptor #(
  parameter int S_LINE   = 256,
  parameter int S_BURST  = 64,
  parameter int S_OFFSET = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adaptor_if.slave   cl_bus
);

  localparam int              N_BURSTS  = S_LINE / S_BURST;
  localparam int              CW        = $clog2(N_BURSTS);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(N_BURSTS - 1);
  localparam logic [31:0]     ADDR_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [S_LINE-1:0]   wline_q, wline_d;
  logic [S_LINE-1:0]   rline_q, rline_d;
  logic [S_BURST-1:0]  wslice [N_BURSTS];
  logic                busy;
  logic                timeout;

  assign busy = (state_q == READ) || (state_q == WRITE);

  for (genvar g = 0; g < N_BURSTS; g++) begin : g_wslice
    assign wslice[g] = wline_q[g*S_BURST +: S_BURST];
  end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic [7:0] idle_q, idle_d;
  logic       err_q;

  // The 255th consecutive stalled cycle is the one that gives up.
  assign timeout = busy && !cl_bus.resp_i && (idle_q == 8'd254);

  always_comb begin
    idle_d = '0;
    if (busy && !cl_bus.resp_i) begin
      idle_d = idle_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= timeout;
    end
  end

  assign cl_bus.error_o = err_q;
`else
  assign timeout        = 1'b0;
  assign cl_bus.error_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        if (cl_bus.write_i) begin
          wline_d = cl_bus.line_i;
          addr_d  = cl_bus.address_i & ADDR_MASK;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (cl_bus.read_i) begin
          addr_d  = cl_bus.address_i & ADDR_MASK;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (cl_bus.resp_i) begin
          for (int b = 0; b < N_BURSTS; b++) begin
            if (cnt_q == CW'(b)) begin
              rline_d[b*S_BURST +: S_BURST] = cl_bus.burst_i;
            end
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (cl_bus.resp_i) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort keeps whatever fill slices already landed in line_o.
    if (timeout) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  assign cl_bus.read_o    = (state_q == READ);
  assign cl_bus.write_o   = (state_q == WRITE);
  assign cl_bus.resp_o    = (state_q == DONE);
  assign cl_bus.address_o = addr_q;
  assign cl_bus.line_o    = rline_q;
  assign cl_bus.burst_o   = (state_q == WRITE) ? wslice[cnt_q] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: randomized line fills/writebacks against a queue-based model.
// Covers reset, no-stall fill, stalled writeback, priority, mid-fill reset, spurious resp_i and timeout.
module tb_cacheline_adaptor;

  localparam int S_LINE  = 256;
  localparam int S_BURST = 64;
  localparam int NB      = S_LINE / S_BURST;
  localparam logic [255:0] FILL_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if #(.S_LINE(S_LINE), .S_BURST(S_BURST)) bus ();

  cacheline_adaptor #(.S_LINE(S_LINE), .S_BURST(S_BURST), .S_OFFSET(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .cl_bus (bus)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [63:0]   pmem_q[$];
  logic [63:0]   exp_wbeat_q[$];
  logic [255:0]  exp_resp_q[$];
  bit            resp_pat_q[$];
  logic [31:0]   exp_addr;
  logic [255:0]  ref_line;
  bit            stall_en;
  bit            hold_off;
  int            beats_seen;
  bit            prev_beat;
  bit            beat_now;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Reference model: a writeback emits the line's slices LSB first; a fill line is its beats concatenated.
  task automatic push_txn(input bit is_wr, input logic [31:0] addr, input logic [255:0] data);
    exp_addr = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < NB; i++) begin
      if (is_wr) exp_wbeat_q.push_back(data[i*64 +: 64]);
      else       pmem_q.push_back(data[i*64 +: 64]);
    end
    if (!is_wr) ref_line = data;
    exp_resp_q.push_back(ref_line);
  endtask

  task automatic wait_busy(input int exp_lat, input bit exp_wr);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.read_o || bus.write_o) break;
    end
    check("start_latency", 256'(n), 256'(exp_lat));
    check("busy_kind", 256'({bus.write_o, bus.read_o}), 256'(exp_wr ? 2'b10 : 2'b01));
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [255:0] data, input int exp_lat);
    push_txn(wr, addr, data);
    bus.address_i = addr;
    bus.line_i    = wr ? data : rand_line();
    bus.read_i    = rd;
    bus.write_i   = wr;
    wait_busy(exp_lat, wr);
    bus.address_i = $urandom;
    bus.line_i    = rand_line();
  endtask

  task automatic wait_resp(input bit keep_rd, output int cycles);
    bit ok;
    ok     = 1'b0;
    cycles = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (bus.resp_o) begin
        ok = 1'b1;
        break;
      end
      cycles++;
    end
    check("resp_seen", 256'(ok), 256'(1));
    bus.read_i  = keep_rd;
    bus.write_i = 1'b0;
  endtask

  // pmem model: serves queued fill beats, drives resp_i from a pattern, randomly, or held.
  initial begin
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    forever begin
      @(posedge clk); #1;
      if ((bus.read_o || bus.write_o) && resp_pat_q.size() > 0) bus.resp_i = resp_pat_q.pop_front();
      else if (hold_off)  bus.resp_i = 1'b0;
      else if (!stall_en) bus.resp_i = 1'b1;
      else                bus.resp_i = ($urandom_range(0, 3) != 0);
      if (bus.read_o && pmem_q.size() > 0) bus.burst_i = pmem_q[0];
      else                                 bus.burst_i = {$urandom, $urandom};
      @(negedge clk);
      if (bus.read_o && bus.resp_i && pmem_q.size() > 0) void'(pmem_q.pop_front());
    end
  end

  // Monitor: compares every pmem-side beat and every completion against the expected queues.
  always @(negedge clk) begin
    if (!rst) begin
      beats_seen = 0;
      prev_beat  = 1'b0;
    end else begin
      if (bus.read_o || bus.write_o) begin
        check("rd_wr_exclusive", 256'(bus.read_o & bus.write_o), 256'(0));
        check("address_o", 256'(bus.address_o), 256'(exp_addr));
      end
      if (bus.write_o) begin
        if (exp_wbeat_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wbeat_underflow: burst_o %h with no beat expected", bus.burst_o);
        end else begin
          check("burst_o", 256'(bus.burst_o), 256'(exp_wbeat_q[0]));
          if (bus.resp_i) void'(exp_wbeat_q.pop_front());
        end
      end
      if (bus.resp_o) begin
        check("beats_before_resp", 256'(beats_seen), 256'(NB));
        check("resp_after_last_beat", 256'(prev_beat), 256'(1));
        check("idle_bus_in_done", 256'(bus.read_o | bus.write_o), 256'(0));
        check("error_o_on_resp", 256'(bus.error_o), 256'(0));
        if (exp_resp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_resp: resp_o with no transaction outstanding");
        end else begin
          check("line_o", bus.line_o, exp_resp_q.pop_front());
        end
        beats_seen = 0;
      end
      beat_now = (bus.read_o || bus.write_o) && bus.resp_i;
      if (beat_now) beats_seen++;
      prev_beat = beat_now;
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           cyc;
    int           gap;
    bit           wr;
    bit           rd;
    logic [255:0] d1;
    logic [6:0]   pat;
    bit           tmo_seen;

    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    stall_en      = 1'b1;
    hold_off      = 1'b0;
    ref_line      = '0;
    exp_addr      = '0;
    rst = 1'b1;
    #1 rst = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_read_o",    256'(bus.read_o),    256'(0));
    check("rst_write_o",   256'(bus.write_o),   256'(0));
    check("rst_resp_o",    256'(bus.resp_o),    256'(0));
    check("rst_error_o",   256'(bus.error_o),   256'(0));
    check("rst_line_o",    bus.line_o,          256'(0));
    check("rst_burst_o",   256'(bus.burst_o),   256'(0));
    check("rst_address_o", 256'(bus.address_o), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill with no stalls
    stall_en = 1'b0;
    issue(1'b1, 1'b0, 32'h0000_1234, FILL_LINE, 1);
    check("fill_address_o", 256'(bus.address_o), 256'(32'h0000_1220));
    wait_resp(1'b0, cyc);
    check("fill_busy_cycles", 256'(cyc), 256'(4));
    check("fill_line_o", bus.line_o, FILL_LINE);

    // Writeback with resp_i pattern 1,0,0,1,1,0,1
    @(posedge clk); #1;
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) resp_pat_q.push_back(pat[i]);
    issue(1'b0, 1'b1, $urandom, rand_line(), 1);
    wait_resp(1'b0, cyc);
    check("wb_busy_cycles", 256'(cyc), 256'(7));
    check("wb_keeps_line_o", bus.line_o, FILL_LINE);

    // Both requests together: write first, then the held read after one IDLE cycle
    @(posedge clk); #1;
    issue(1'b1, 1'b1, $urandom, rand_line(), 1);
    wait_resp(1'b1, cyc);
    issue(1'b1, 1'b0, $urandom, rand_line(), 2);
    wait_resp(1'b0, cyc);

    // Reset in the middle of a fill
    @(posedge clk); #1;
    d1 = rand_line();
    issue(1'b1, 1'b0, 32'hABCD_0047, d1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("partial_fill", 256'(bus.line_o[127:0]), 256'(d1[127:0]));
    #2 rst = 1'b0;
    #1;
    check("arst_read_o",  256'(bus.read_o),  256'(0));
    check("arst_resp_o",  256'(bus.resp_o),  256'(0));
    check("arst_line_o",  bus.line_o,        256'(0));
    check("arst_address", 256'(bus.address_o), 256'(0));
    pmem_q.delete();
    exp_wbeat_q.delete();
    exp_resp_q.delete();
    ref_line = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_0F1F, rand_line(), 1);
    wait_resp(1'b0, cyc);
    check("post_reset_fill_cycles", 256'(cyc), 256'(4));

    // Randomized traffic with stalls, idle gaps and spurious resp_i
    stall_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 2);
      wr  = 1'($urandom_range(0, 1));
      rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      issue(rd, wr, $urandom, rand_line(), (gap == 0) ? 2 : 1);
      wait_resp(1'b0, cyc);
    end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    // Stalled fill must give up after 255 cycles without resp_o
    @(posedge clk); #1;
    hold_off      = 1'b1;
    exp_addr      = 32'h0000_8000;
    bus.address_i = 32'h0000_8000;
    bus.read_i    = 1'b1;
    wait_busy(1, 1'b0);
    tmo_seen = 1'b0;
    cyc      = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.error_o) begin
        tmo_seen = 1'b1;
        break;
      end
    end
    bus.read_i = 1'b0;
    check("timeout_seen",   256'(tmo_seen),   256'(1));
    check("timeout_cycle",  256'(cyc),        256'(256));
    check("timeout_read_o", 256'(bus.read_o), 256'(0));
    check("timeout_resp_o", 256'(bus.resp_o), 256'(0));
    @(posedge clk); #1;
    check("timeout_pulse",  256'(bus.error_o), 256'(0));
    check("timeout_no_resp", 256'(bus.resp_o), 256'(0));
    hold_off = 1'b0;
`else
    tmo_seen = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #1;
    check("resp_q_drained",  256'(exp_resp_q.size()),  256'(0));
    check("wbeat_q_drained", 256'(exp_wbeat_q.size()), 256'(0));
    check("pmem_q_drained",  256'(pmem_q.size()),      256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
